master_request_router: RTL

//  Per-master front end to the per-slave arbiters. Decodes the master's slave address into a one-hot request vector.

---
 rtl/master_request_router_if.sv | 25 ++
 rtl/master_request_router.sv | 122 ++++++++++++
 2 files changed

// File: rtl/master_request_router_if.sv
// Handshake bundle between one master, its request router and the per-slave arbiters.
interface master_request_router_if #(
  parameter int QTY_OF_DEVICES = 4
);
  localparam int ADDR_W = $clog2(QTY_OF_DEVICES);

  logic [ADDR_W-1:0]         address;
  logic                      request_from_master;
  logic [QTY_OF_DEVICES-1:0] grant_from_arbiters;
  logic [QTY_OF_DEVICES-1:0] request_to_arbiters;
  logic                      ack_to_master;
  logic                      busy;
  logic                      error;

  // Master side drives the request, address and arbiter grants; the router answers.
  modport master (
    output address, request_from_master, grant_from_arbiters,
    input  request_to_arbiters, ack_to_master, busy, error
  );

  modport slave (
    input  address, request_from_master, grant_from_arbiters,
    output request_to_arbiters, ack_to_master, busy, error
  );
endinterface

// File: rtl/master_request_router.sv
// Per-master router: decodes address to a one-hot arbiter request, holds it until granted, locks the target.
// Optional REQ_ROUTER_TIMEOUT_EN aborts a request left ungranted for TIMEOUT_CYCLES.
module master_request_router #(
  parameter int QTY_OF_DEVICES = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input logic                    clk,
  input logic                    rst,
  master_request_router_if.slave bus
);
  localparam int ADDR_W = $clog2(QTY_OF_DEVICES);

  typedef enum logic [1:0] {IDLE, REQ, GRANT, ERR} state_t;

  state_t                    state;
  logic [ADDR_W-1:0]         target;
  logic [QTY_OF_DEVICES-1:0] req_vec;
  logic                      ack;
  logic                      busy_q;
  logic                      error_q;

  logic                      addr_ok;
  logic                      grant_tgt;
  logic [QTY_OF_DEVICES-1:0] addr_onehot;

  // Widen before comparing so non-power-of-two device counts decode correctly.
  assign addr_ok     = (32'(bus.address) < 32'(QTY_OF_DEVICES));
  assign grant_tgt   = bus.grant_from_arbiters[target];
  assign addr_onehot = {{(QTY_OF_DEVICES-1){1'b0}}, 1'b1} << bus.address;

`ifdef REQ_ROUTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      target  <= '0;
      req_vec <= '0;
      ack     <= 1'b0;
      busy_q  <= 1'b0;
      error_q <= 1'b0;
`ifdef REQ_ROUTER_TIMEOUT_EN
      wait_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.request_from_master) begin
            busy_q <= 1'b1;
            if (addr_ok) begin
              state   <= REQ;
              target  <= bus.address;
              req_vec <= addr_onehot;
`ifdef REQ_ROUTER_TIMEOUT_EN
              wait_cnt <= '0;
`endif
            end else begin
              state   <= ERR;
              error_q <= 1'b1;
            end
          end
        end
        REQ: begin
          // Master drop takes priority over a grant arriving in the same cycle.
          if (!bus.request_from_master) begin
            state   <= IDLE;
            req_vec <= '0;
            ack     <= 1'b0;
            busy_q  <= 1'b0;
          end else if (grant_tgt) begin
            state <= GRANT;
            ack   <= 1'b1;
          end
`ifdef REQ_ROUTER_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES)) begin
            state   <= ERR;
            req_vec <= '0;
            error_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        GRANT: begin
          if (!bus.request_from_master) begin
            state   <= IDLE;
            req_vec <= '0;
            ack     <= 1'b0;
            busy_q  <= 1'b0;
          end else if (!grant_tgt) begin
            state <= REQ;
            ack   <= 1'b0;
`ifdef REQ_ROUTER_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end
        ERR: begin
          if (!bus.request_from_master) begin
            state   <= IDLE;
            error_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          req_vec <= '0;
          ack     <= 1'b0;
          busy_q  <= 1'b0;
          error_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.request_to_arbiters = req_vec;
  assign bus.ack_to_master       = ack;
  assign bus.busy                = busy_q;
  assign bus.error               = error_q;
endmodule
